// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder
//
// Single-port memory target for a simple level-valid request bus. It takes
// one request at a time and answers after a fixed number of cycles with a
// one-cycle response pulse. Byte, halfword and word accesses are supported,
// and lanes are little-endian. Misaligned or malformed accesses are answered
// with an error flag. An error response suppresses the write and returns zero.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two); the word index wraps
//   LATENCY  cycles from request acceptance to response (>= 1)
//
// Ports
//   i_clk             clock, all state on the rising edge
//   i_rst_n           synchronous active-low reset
//   i_bus_address     byte address
//   i_bus_data        write data, right-aligned
//   i_bus_DV          request valid (level, held until o_bus_DV is seen)
//   i_bhw             access size, one-hot {word, half, byte}
//   i_write_notread   1 = write, 0 = read
//   o_bus_data        read data, right-aligned, zero-extended
//   o_bus_DV          one-cycle response pulse
//   o_bus_err         qualifies o_bus_DV, 1 = access rejected
// ---------------------------------------------------------------------------
module bus_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_bus_address,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic        o_bus_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  // The BUSY countdown runs from LATENCY-2 to 0 and then moves to RESP.
  // Only LATENCY > 1 ever loads it.
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Latched request. Only the address bits that select a word and lane are kept.
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      bhw_q;
  logic            we_q;

  logic [31:0]     rdata_q;
  logic            dv_q;
  logic            err_q;

  // Upper address bits are ignored, so the word index wraps modulo DEPTH.
  logic [31-AW-2:0] unused_addr_bits;
  assign unused_addr_bits = i_bus_address[31:AW+2];

  logic            take_req;
  logic            respond;
  logic            bad_access;
  logic [3:0]      lane_sel;
  logic [3:0]      lane_we;
  logic [31:0]     wdata_lanes;
  logic [31:0]     rd_word;
  logic [31:0]     rd_fmt;
  logic [AW-1:0]   word_idx;

  assign take_req = (state_q == IDLE) && i_bus_DV;
  assign respond  = (state_q == RESP);
  assign word_idx = addr_q[AW+1:2];

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_bus_DV) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        // Wait for the initiator to drop its request so that it is not served twice.
        if (!i_bus_DV) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Access decode on the latched request
  // -------------------------------------------------------------------------
  always_comb begin
    bad_access  = 1'b1;
    lane_sel    = 4'b0000;
    wdata_lanes = wdata_q;
    case (bhw_q)
      3'b001: begin
        bad_access  = 1'b0;
        lane_sel    = 4'b0001 << addr_q[1:0];
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      3'b010: begin
        bad_access  = addr_q[0];
        lane_sel    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      3'b100: begin
        bad_access  = (addr_q[1:0] != 2'b00);
        lane_sel    = 4'b1111;
        wdata_lanes = wdata_q;
      end
      default: begin
        bad_access  = 1'b1;
        lane_sel    = 4'b0000;
        wdata_lanes = wdata_q;
      end
    endcase
  end

  // Gate the write with reset, so that a reset on the commit edge also aborts the write.
  assign lane_we = (respond && we_q && !bad_access && i_rst_n) ? lane_sel : 4'b0000;

  // -------------------------------------------------------------------------
  // Storage: one byte-wide array per lane, which gives independent lane writes
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge i_clk) begin
        if (lane_we[gi]) begin
          lane_mem[word_idx] <= wdata_lanes[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Right-align the addressed lane(s) and zero-extend them.
  always_comb begin
    rd_fmt = 32'h0;
    case (bhw_q)
      3'b001:  rd_fmt = {24'h0, rd_word[{addr_q[1:0], 3'b000} +: 8]};
      3'b010:  rd_fmt = {16'h0, rd_word[{addr_q[1], 4'b0000} +: 16]};
      3'b100:  rd_fmt = rd_word;
      default: rd_fmt = 32'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, request latch and response registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      bhw_q   <= 3'b000;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      // Inputs are sampled only at acceptance. Changes while busy are ignored.
      if (take_req) begin
        addr_q  <= i_bus_address[AW+1:0];
        wdata_q <= i_bus_data;
        bhw_q   <= i_bhw;
        we_q    <= i_write_notread;
      end

      dv_q <= respond;
      // Data and error keep their value until the next response.
      if (respond) begin
        err_q   <= bad_access;
        rdata_q <= (bad_access || we_q) ? 32'h0 : rd_fmt;
      end
    end
  end

  assign o_bus_data = rdata_q;
  assign o_bus_DV   = dv_q;
  assign o_bus_err  = err_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_responder
//
// Bench for bus_mem_responder. Index 0 is a LATENCY=1 instance and index 1 is
// a LATENCY=4 instance. Both have DEPTH=1024. A table of directed accesses
// runs on the LATENCY=1 instance. Hand-written sequences cover the held
// request, reset during BUSY and a request held across reset release on the
// LATENCY=4 instance.
// ---------------------------------------------------------------------------
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        req   [2];
  logic [2:0]  bhw   [2];
  logic        wnr   [2];
  logic [31:0] rdata [2];
  logic        rsp   [2];
  logic        err   [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_bus_address   (addr[0]),
    .i_bus_data      (wdata[0]),
    .i_bus_DV        (req[0]),
    .i_bhw           (bhw[0]),
    .i_write_notread (wnr[0]),
    .o_bus_data      (rdata[0]),
    .o_bus_DV        (rsp[0]),
    .o_bus_err       (err[0])
  );

  bus_mem_responder #(.DEPTH(1024), .LATENCY(4)) dut_l4 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_bus_address   (addr[1]),
    .i_bus_data      (wdata[1]),
    .i_bus_DV        (req[1]),
    .i_bhw           (bhw[1]),
    .i_write_notread (wnr[1]),
    .o_bus_data      (rdata[1]),
    .o_bus_DV        (rsp[1]),
    .o_bus_err       (err[1])
  );

  typedef struct {
    logic        we;
    logic [2:0]  bhw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Performs one full handshake on instance sel and checks the latency,
  // the response contents and the single-cycle pulse.
  task automatic do_txn(input int sel, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk_data, input logic [31:0] exp_data,
                        input logic exp_err, input string name);
    int lat;
    int exp_lat;
    exp_lat    = (sel == 0) ? 2 : 5;
    lat        = 0;
    addr[sel]  = a;
    wdata[sel] = d;
    bhw[sel]   = sz;
    wnr[sel]   = we;
    req[sel]   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp[sel] === 1'b1) begin
        lat = c;
        break;
      end
    end
    req[sel] = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_err"}, err[sel], exp_err);
    if (chk_data) check({name, "_data"}, rdata[sel], exp_data);
    $display("txn %-14s dut=%0d we=%0b bhw=%b addr=%h wdata=%h -> data=%h err=%0b lat=%0d",
             name, sel, we, sz, a, d, rdata[sel], err[sel], lat);
    @(negedge clk);
    check({name, "_pulse_end"}, rsp[sel], 1'b0);
    check({name, "_err_hold"}, err[sel], exp_err);
  endtask

  initial begin
    int pulses;
    int first_pulse;
    int lat;

    vecs[0]  = '{1'b1, 3'b100, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, "w_word_10"};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF,  1'b0, "r_word_10"};
    vecs[2]  = '{1'b1, 3'b100, 32'h0000_0010, 32'h11223344, 1'b0, 32'h0,         1'b0, "w_word_base"};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0013, 32'hFFFF_FFAA, 1'b0, 32'h0,        1'b0, "w_byte_13"};
    vecs[4]  = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,        1'b1, 32'hAA223344,  1'b0, "r_word_after_b"};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0013, 32'h0,        1'b1, 32'h000000AA,  1'b0, "r_byte_13"};
    vecs[6]  = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,        1'b1, 32'h00000044,  1'b0, "r_byte_10"};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_0012, 32'h0,        1'b1, 32'h0000AA22,  1'b0, "r_half_12"};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0011, 32'h0,        1'b1, 32'h0,         1'b1, "r_half_mis"};
    vecs[9]  = '{1'b0, 3'b100, 32'h0000_0012, 32'h0,        1'b1, 32'h0,         1'b1, "r_word_mis"};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_0011, 32'h0000FFFF, 1'b1, 32'h0,         1'b1, "w_half_mis"};
    vecs[11] = '{1'b1, 3'b011, 32'h0000_0010, 32'h0,        1'b1, 32'h0,         1'b1, "w_bad_bhw"};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0010, 32'h0,        1'b1, 32'h0,         1'b1, "r_zero_bhw"};
    vecs[13] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,        1'b1, 32'hAA223344,  1'b0, "r_unchanged"};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_0012, 32'h1234BEEF, 1'b0, 32'h0,         1'b0, "w_half_12"};
    vecs[15] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,        1'b1, 32'hBEEF3344,  1'b0, "r_word_after_h"};
    vecs[16] = '{1'b1, 3'b100, 32'h0000_1000, 32'h00000005, 1'b0, 32'h0,         1'b0, "w_word_1000"};
    vecs[17] = '{1'b0, 3'b100, 32'h0000_0000, 32'h0,        1'b1, 32'h00000005,  1'b0, "r_word_wrap"};
    vecs[18] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,        1'b1, 32'h00000005,  1'b0, "r_half_0"};
    vecs[19] = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,        1'b1, 32'h00000000,  1'b0, "r_byte_1"};

    for (int s = 0; s < 2; s++) begin
      addr[s] = 32'h0; wdata[s] = 32'h0; req[s] = 1'b0; bhw[s] = 3'b100; wnr[s] = 1'b0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_dv",   rsp[s],   1'b0);
      check("reset_err",  err[s],   1'b0);
      check("reset_data", rdata[s], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table of directed accesses on the LATENCY=1 instance
    for (int i = 0; i < NVEC; i++) begin
      do_txn(0, vecs[i].we, vecs[i].bhw, vecs[i].addr, vecs[i].wdata,
             vecs[i].chk_data, vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
    end

    // LATENCY=4: request held for 10 cycles. The inputs change while the
    // request is being served.
    addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D; bhw[1] = 3'b100; wnr[1] = 1'b1;
    req[1]  = 1'b1;
    pulses = 0; first_pulse = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        addr[1] = 32'h40; wdata[1] = 32'h0;
      end
      if (rsp[1] === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = c;
      end
    end
    check("held_pulse_count", pulses, 1);
    check("held_pulse_at", first_pulse, 5);
    $display("txn held_req       dut=1 pulses=%0d first_at=%0d", pulses, first_pulse);
    req[1] = 1'b0;
    @(negedge clk);
    do_txn(1, 1'b0, 3'b100, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "l4_r_word_20");

    // LATENCY=4: reset two cycles into a write
    do_txn(1, 1'b1, 3'b100, 32'h30, 32'h01020304, 1'b0, 32'h0, 1'b0, "l4_w_word_30");
    addr[1] = 32'h30; wdata[1] = 32'hFFFFFFFF; bhw[1] = 3'b100; wnr[1] = 1'b1;
    req[1]  = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp[1] === 1'b1) pulses++;
    end
    rst_n  = 1'b0;
    req[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp[1] === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp[1] === 1'b1) pulses++;
    end
    check("abort_no_dv", pulses, 0);
    $display("txn reset_abort    dut=1 pulses=%0d", pulses);
    do_txn(1, 1'b0, 3'b100, 32'h30, 32'h0, 1'b1, 32'h01020304, 1'b0, "l4_r_after_abort");
    // Reset does not clear the memory of the other instance.
    do_txn(0, 1'b0, 3'b100, 32'h0, 32'h0, 1'b1, 32'h00000005, 1'b0, "l1_r_after_rst");

    // A request held high across reset release is accepted at the first edge out of reset.
    rst_n = 1'b0;
    addr[1] = 32'h30; bhw[1] = 3'b001; wnr[1] = 1'b0; req[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp[1] === 1'b1) begin
        lat = c;
        break;
      end
    end
    req[1] = 1'b0;
    check("rel_latency", lat, 5);
    check("rel_data", rdata[1], 32'h00000004);
    check("rel_err", err[1], 1'b0);
    $display("txn held_over_rst  dut=1 data=%h lat=%0d", rdata[1], lat);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
